// File: rtl/restoring_divider.sv
`default_nettype none
// ============================================================================
//  Module   : restoring_divider
//  Purpose  : Sequential unsigned restoring divider. Accepts a dividend and a
//             divisor on a start pulse. Produces one quotient bit every two
//             clock cycles (SHIFT, then SUBTEST). Reports quotient,
//             remainder and a divide-by-zero flag, with a one-cycle done
//             pulse.
//  Ports    :
//      clk          - system clock, rising edge
//      rst          - asynchronous, active-low reset
//      start        - division request, sampled only while idle
//      dividend     - unsigned dividend, captured in LOAD
//      divisor      - unsigned divisor, captured in LOAD
//      quotient     - registered quotient (all ones on divide by zero)
//      remainder    - registered remainder (dividend on divide by zero)
//      div_by_zero  - registered flag, captured divisor was zero
//      busy         - high in every state except IDLE
//      done         - one-cycle pulse in the DONE state
//  Revision : 1.0 - initial release
// ============================================================================
module restoring_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_SHIFT   = 3'd2,
        S_SUBTEST = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t             state_q,     state_d;
    logic [WIDTH:0]     a_q,         a_d;
    logic [WIDTH-1:0]   q_q,         q_d;
    logic [WIDTH-1:0]   m_q,         m_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [WIDTH-1:0]   quotient_q,  quotient_d;
    logic [WIDTH-1:0]   remainder_q, remainder_d;
    logic               dbz_q,       dbz_d;
    logic               busy_q,      busy_d;
    logic               done_q,      done_d;

    // Trial subtraction. The shifted partial remainder is always below 2*M,
    // so a negative result is always visible in the extra top bit.
    logic [WIDTH:0]     w_trial;
    assign w_trial = a_q - {1'b0, m_q};

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        q_d         = q_q;
        m_d         = m_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                a_d   = '0;
                q_d   = dividend;
                m_d   = divisor;
                cnt_d = CNT_W'(WIDTH);
                dbz_d = 1'b0;
                if (divisor == '0) begin
                    dbz_d       = 1'b1;
                    quotient_d  = '1;
                    remainder_d = dividend;
                    state_d     = S_DONE;
                end else begin
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // {A,Q} shifted left as one register, zero into the Q LSB.
                {a_d, q_d} = {a_q[WIDTH-1:0], q_q, 1'b0};
                state_d    = S_SUBTEST;
            end
            S_SUBTEST: begin
                if (w_trial[WIDTH]) begin
                    // Negative: keep A as it is (restore), quotient bit 0.
                    q_d = {q_q[WIDTH-1:1], 1'b0};
                end else begin
                    a_d = w_trial;
                    q_d = {q_q[WIDTH-1:1], 1'b1};
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    // Last bit: publish the freshly updated Q/A directly.
                    quotient_d  = q_d;
                    remainder_d = a_d[WIDTH-1:0];
                    state_d     = S_DONE;
                end else begin
                    state_d = S_SHIFT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status outputs are registered from the next state so they line up
        // with the state they describe.
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            q_q         <= '0;
            m_q         <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            q_q         <= q_d;
            m_q         <= m_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_restoring_divider.sv
`default_nettype none
// ============================================================================
//  Module   : tb_restoring_divider
//  Purpose  : Self-checking bench for restoring_divider (WIDTH=4). Expected
//             results come from plain / and % arithmetic, with the
//             divide-by-zero convention applied explicitly.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_restoring_divider;

    localparam int WIDTH    = 4;
    localparam int NORM_LAT = 2 * WIDTH + 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] dividend = '0;
    logic [WIDTH-1:0] divisor = '0;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;

    restoring_divider #(.WIDTH(WIDTH)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Runs one division and checks latency, busy span, results and the
    // quiet cycle after DONE. With disturb set, start is toggled and the
    // operands are scrambled after capture.
    task automatic run_div(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit disturb);
        logic [WIDTH-1:0] eq, er;
        logic             ed;
        int               exp_lat, lat, busy_cnt, done_cnt;
        if (b == 0) begin
            eq = '1; er = a; ed = 1'b1; exp_lat = 2;
        end else begin
            eq = a / b; er = a % b; ed = 1'b0; exp_lat = NORM_LAT;
        end
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        lat = 0; busy_cnt = 0; done_cnt = 0;
        for (int cyc = 1; cyc <= NORM_LAT + 4 && lat == 0; cyc++) begin
            @(negedge clk);
            if (disturb && cyc < exp_lat - 1) begin
                start = 1'(($urandom) & 1);
                if (cyc >= 2) begin
                    dividend = WIDTH'($urandom);
                    divisor  = WIDTH'($urandom);
                end
            end else begin
                start = 1'b0;
            end
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                lat = cyc;
            end
        end
        check_eq("latency", lat, exp_lat);
        check_eq("busy_cycles", busy_cnt, exp_lat);
        check_eq("quotient", quotient, eq);
        check_eq("remainder", remainder, er);
        check_eq("div_by_zero", div_by_zero, ed);
        start = 1'b0;
        @(negedge clk);
        check_eq("done_single_pulse", done, 1'b0);
        check_eq("idle_after_done", busy, 1'b0);
        check_eq("quotient_stable", quotient, eq);
    endtask

    // Waits (bounded) for done; returns the cycle count or 0 on timeout.
    task automatic wait_done(output int cycles);
        cycles = 0;
        for (int i = 1; i <= NORM_LAT + 6 && cycles == 0; i++) begin
            @(negedge clk);
            if (done) cycles = i;
        end
    endtask

    initial begin
        int n, dcount;

        // Reset state
        #1 rst = 1'b0;
        #1;
        check_eq("reset_quotient", quotient, 0);
        check_eq("reset_remainder", remainder, 0);
        check_eq("reset_dbz", div_by_zero, 0);
        check_eq("reset_busy", busy, 0);
        check_eq("reset_done", done, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Directed operands
        run_div(4'd13, 4'd3, 1'b0);
        run_div(4'd15, 4'd1, 1'b0);
        run_div(4'd3,  4'd9, 1'b0);
        run_div(4'd7,  4'd0, 1'b0);
        run_div(4'd8,  4'd2, 1'b0);

        // Restart attempts and operand changes while busy
        run_div(4'd14, 4'd5, 1'b1);
        run_div(4'd9,  4'd0, 1'b1);

        // start held high: the IDLE cycle after DONE launches a new run
        @(negedge clk);
        dividend = 4'd13;
        divisor  = 4'd3;
        start    = 1'b1;
        wait_done(n);
        check_eq("held_first_done", (n != 0), 1'b1);
        @(negedge clk);
        check_eq("held_idle_gap", busy, 1'b0);
        @(negedge clk);
        check_eq("held_restart", busy, 1'b1);
        start = 1'b0;
        wait_done(n);
        check_eq("held_second_latency", n, NORM_LAT - 1);
        check_eq("held_quotient", quotient, 4'd4);
        check_eq("held_remainder", remainder, 4'd1);

        // Asynchronous reset in the middle of an iteration
        run_div(4'd7, 4'd0, 1'b0);
        @(negedge clk);
        dividend = 4'd13;
        divisor  = 4'd3;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check_eq("async_rst_quotient", quotient, 0);
        check_eq("async_rst_remainder", remainder, 0);
        check_eq("async_rst_dbz", div_by_zero, 0);
        check_eq("async_rst_busy", busy, 0);
        check_eq("async_rst_done", done, 0);
        dcount = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) dcount++;
        end
        rst = 1'b1;
        repeat (NORM_LAT + 2) begin
            @(negedge clk);
            if (done || busy) dcount++;
        end
        check_eq("abandoned_no_done", dcount, 0);
        run_div(4'd13, 4'd3, 1'b0);

        // Exhaustive operand sweep
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_div(WIDTH'(a), WIDTH'(b), 1'b0);
            end
        end

        // Random operands with random disturbance
        for (int k = 0; k < 40; k++) begin
            run_div(WIDTH'($urandom), WIDTH'($urandom), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
